// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: ID/EX control-hazard signal bundle for branch_ctrl.
// master = pipeline side (drives ID/EX information, receives redirect/flush),
// slave  = branch_ctrl itself.
interface branch_ctrl_if;
    // ID stage
    logic        i_id_valid;
    logic [31:0] i_id_pc;
    logic        i_id_is_branch;
    logic        i_id_is_jal;
    logic [31:0] i_id_target;
    logic        i_stall;
    // EX stage
    logic        i_ex_valid;
    logic [31:0] i_ex_pc;
    logic        i_ex_is_branch;
    logic        i_ex_is_jalr;
    logic        i_ex_pc_sel;
    logic        i_ex_pred_taken;
    logic [31:0] i_ex_target;
    logic [31:0] i_ex_pc_plus4;
    // Controller outputs
    logic        o_id_pred_taken;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic        o_flush_ifid;
    logic        o_flush_idex;
    logic [31:0] o_br_cnt;
    logic [31:0] o_misp_cnt;

    modport master (
        output i_id_valid, i_id_pc, i_id_is_branch, i_id_is_jal, i_id_target, i_stall,
        output i_ex_valid, i_ex_pc, i_ex_is_branch, i_ex_is_jalr, i_ex_pc_sel,
        output i_ex_pred_taken, i_ex_target, i_ex_pc_plus4,
        input  o_id_pred_taken, o_redirect, o_redirect_pc, o_flush_ifid, o_flush_idex,
        input  o_br_cnt, o_misp_cnt
    );

    modport slave (
        input  i_id_valid, i_id_pc, i_id_is_branch, i_id_is_jal, i_id_target, i_stall,
        input  i_ex_valid, i_ex_pc, i_ex_is_branch, i_ex_is_jalr, i_ex_pc_sel,
        input  i_ex_pred_taken, i_ex_target, i_ex_pc_plus4,
        output o_id_pred_taken, o_redirect, o_redirect_pc, o_flush_ifid, o_flush_idex,
        output o_br_cnt, o_misp_cnt
    );
endinterface

// File: rtl/branch_ctrl.sv
// branch_ctrl: control-hazard controller for the pipelined RV32I core.
// Predicts direction in ID, resolves in EX, drives PC redirect and pipeline
// flushes, and keeps saturating resolved-branch / mispredict counters.
// Optional 2-bit branch history table built when BRANCH_CTRL_BHT_EN is
// defined; otherwise conditional branches are statically predicted not-taken.
module branch_ctrl #(
    parameter int unsigned BHT_IDX_W = 6
) (
    input logic         i_clk,
    input logic         i_rst_n,
    branch_ctrl_if.slave bus
);

    logic        pred_bit;
    logic        id_pred;
    logic        ex_misp;
    logic        ex_br_ev;
    logic        id_redir;
    logic [31:0] br_cnt_d,   br_cnt_q;
    logic [31:0] misp_cnt_d, misp_cnt_q;

`ifdef BRANCH_CTRL_BHT_EN
    localparam int unsigned BHT_DEPTH = 1 << BHT_IDX_W;

    logic [1:0]           bht_q [BHT_DEPTH];
    logic                 upd_vld_d,   upd_vld_q;
    logic                 upd_taken_d, upd_taken_q;
    logic [BHT_IDX_W-1:0] upd_idx_d,   upd_idx_q;
    logic [BHT_IDX_W-1:0] id_idx;
    logic [1:0]           upd_old;
    logic [1:0]           upd_new;

    // Move a 2-bit counter one step toward the outcome, saturating at 00/11.
    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != 2'b11) res = cnt + 2'd1;
        end else begin
            if (cnt != 2'b00) res = cnt - 2'd1;
        end
        return res;
    endfunction

    // Capture resolving branches, compute the pending entry value and the
    // ID-side prediction bit with bypass from the pending update.
    always_comb begin
        id_idx      = bus.i_id_pc[BHT_IDX_W+1:2];
        upd_vld_d   = bus.i_ex_valid & bus.i_ex_is_branch;
        upd_idx_d   = bus.i_ex_pc[BHT_IDX_W+1:2];
        upd_taken_d = bus.i_ex_pc_sel;
        upd_old     = bht_q[upd_idx_q];
        upd_new     = sat_step(upd_old, upd_taken_q);
        if (upd_vld_q && (id_idx == upd_idx_q)) begin
            pred_bit = upd_new[1];
        end else begin
            pred_bit = bht_q[id_idx][1];
        end
    end

    // Table write one cycle after resolution; reset reinitialises every entry
    // to weakly not-taken and drops any pending write.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i[BHT_IDX_W-1:0]] <= 2'b01;
            end
            upd_vld_q   <= 1'b0;
            upd_idx_q   <= '0;
            upd_taken_q <= 1'b0;
        end else begin
            if (upd_vld_q) begin
                bht_q[upd_idx_q] <= upd_new;
            end
            upd_vld_q   <= upd_vld_d;
            upd_idx_q   <= upd_idx_d;
            upd_taken_q <= upd_taken_d;
        end
    end
`else
    logic [BHT_IDX_W-1:0] unused_id_idx;

    // Static predict-not-taken for conditional branches.
    always_comb begin
        pred_bit = 1'b0;
    end

    assign unused_id_idx = bus.i_id_pc[BHT_IDX_W+1:2];
`endif

    // Full PCs are only partly consumed (index bits, or nothing without a table).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.i_id_pc, bus.i_ex_pc};

    // Prediction, resolution and redirect/flush selection; EX mispredict wins.
    always_comb begin
        id_pred  = bus.i_id_valid & (bus.i_id_is_jal | (bus.i_id_is_branch & pred_bit));
        ex_br_ev = bus.i_ex_valid & bus.i_ex_is_branch;
        ex_misp  = bus.i_ex_valid &
                   ((bus.i_ex_is_branch & (bus.i_ex_pc_sel ^ bus.i_ex_pred_taken)) |
                    bus.i_ex_is_jalr);
        id_redir = id_pred & ~bus.i_stall & ~ex_misp;

        bus.o_id_pred_taken = id_pred;
        bus.o_redirect      = 1'b0;
        bus.o_redirect_pc   = bus.i_ex_pc_plus4;
        bus.o_flush_ifid    = 1'b0;
        bus.o_flush_idex    = 1'b0;

        if (ex_misp) begin
            bus.o_redirect    = 1'b1;
            bus.o_redirect_pc = bus.i_ex_pc_sel ? bus.i_ex_target : bus.i_ex_pc_plus4;
            bus.o_flush_ifid  = 1'b1;
            bus.o_flush_idex  = 1'b1;
        end else if (id_redir) begin
            bus.o_redirect    = 1'b1;
            bus.o_redirect_pc = bus.i_id_target;
            bus.o_flush_ifid  = 1'b1;
        end
    end

    // Saturating next-count for both statistics counters.
    always_comb begin
        br_cnt_d   = br_cnt_q;
        misp_cnt_d = misp_cnt_q;
        if (ex_br_ev && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + 32'd1;
        end
        if (ex_misp && (misp_cnt_q != '1)) begin
            misp_cnt_d = misp_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            br_cnt_q   <= '0;
            misp_cnt_q <= '0;
        end else begin
            br_cnt_q   <= br_cnt_d;
            misp_cnt_q <= misp_cnt_d;
        end
    end

    assign bus.o_br_cnt   = br_cnt_q;
    assign bus.o_misp_cnt = misp_cnt_q;

endmodule
